// File: rtl/bcd2bin_if.sv
// ---------------------------------------------------------------------------
// bcd2bin_if
// Handshake/data bundle for the packed-BCD to binary converter.
//
// Signals:
//   start    requester -> converter  request a conversion (sampled when idle)
//   bcd_in   requester -> converter  packed BCD operand, MS digit in high nibble
//   busy     converter -> requester  conversion in progress
//   done     converter -> requester  one-cycle pulse, bin_out/err valid
//   bin_out  converter -> requester  binary result, held until next done
//   err      converter -> requester  invalid-digit flag, held until next done
//
// Modports:
//   master  the requester side (drives start/bcd_in)
//   slave   the converter side (drives busy/done/bin_out/err)
// ---------------------------------------------------------------------------
interface bcd2bin_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output err
  );

endinterface

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Each RUN cycle shifts {bcd_reg, bin_acc} right by one bit and then
// subtracts 3 from every BCD digit that ended up >= 8. After BIN_W steps the
// accumulator holds the binary value. One conversion in flight at a time.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd2bin_if.slave: start, bcd_in in; busy, done, bin_out, err out
//
// Parameters:
//   DIGITS  number of packed BCD digits on bcd_in
//   BIN_W   result width and iteration count; needs 2^BIN_W > 10^DIGITS - 1
//
// Optional build macro:
//   BCD2BIN_ERR_CHECK_EN  when defined, nibbles > 9 are rejected at start:
//                         done pulses the next cycle with err=1, bin_out=0.
//                         When undefined, err is tied 0 and every operand is
//                         run through the algorithm.
// ---------------------------------------------------------------------------
module bcd2bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd2bin_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [BCD_W-1:0]   bcd_reg_q, bcd_reg_d;
  logic [BIN_W-1:0]   bin_acc_q, bin_acc_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
`ifdef BCD2BIN_ERR_CHECK_EN
  logic               err_q,     err_d;
`endif

  // -------------------------------------------------------------------------
  // One reverse double-dabble step, computed combinationally from the current
  // shift register: shift right by one, then correct each digit in parallel.
  // -------------------------------------------------------------------------
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       shift_bcd;
  logic [BIN_W-1:0]       shift_acc;
  logic [BCD_W-1:0]       corr_bcd;

  assign shifted   = {bcd_reg_q, bin_acc_q} >> 1;
  assign shift_bcd = shifted[BIN_W +: BCD_W];
  assign shift_acc = shifted[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_corr
      logic [3:0] dig;
      assign dig = shift_bcd[gi*4 +: 4];
      // A digit >= 8 after the shift means a tens-carry of 10 was halved into
      // 5 plus whatever was there; undoing the +3 bias of double-dabble.
      assign corr_bcd[gi*4 +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Invalid-digit detection on the operand presented with start.
  // -------------------------------------------------------------------------
  logic start_reject;

`ifdef BCD2BIN_ERR_CHECK_EN
  logic [DIGITS-1:0] nib_bad;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
      assign nib_bad[gi] = (bus.bcd_in[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  assign start_reject = |nib_bad;
`else
  assign start_reject = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_reg_d = bcd_reg_q;
    bin_acc_d = bin_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bin_out_d = bin_out_q;
`ifdef BCD2BIN_ERR_CHECK_EN
    err_d     = err_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE is a single-cycle state; a start here is accepted as a
        // back-to-back request exactly as from IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          if (start_reject) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            bin_out_d = '0;
`ifdef BCD2BIN_ERR_CHECK_EN
            err_d     = 1'b1;
`endif
          end else begin
            state_d   = ST_RUN;
            bcd_reg_d = bus.bcd_in;
            bin_acc_d = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // start is ignored here: no queuing, no restart.
        bcd_reg_d = corr_bcd;
        bin_acc_d = shift_acc;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d   = ST_DONE;
          bin_out_d = shift_acc;
          done_d    = 1'b1;
          busy_d    = 1'b0;
`ifdef BCD2BIN_ERR_CHECK_EN
          err_d     = 1'b0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bcd_reg_q <= '0;
      bin_acc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_reg_q <= bcd_reg_d;
      bin_acc_q <= bin_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_out_q <= bin_out_d;
`ifdef BCD2BIN_ERR_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered)
  // -------------------------------------------------------------------------
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_out_q;
`ifdef BCD2BIN_ERR_CHECK_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential packed-BCD to binary converter using reverse double-dabble: shift right, then subtract 3 from each digit. It is the decode path for the multiplier block's two-digit BCD product output, so results can be checked and reused in binary. A start/busy/done handshake allows one conversion in flight at a time. Iterative datapath: one shift/correct step per clock.

Parameters:
DIGITS  2  number of packed BCD digits on bcd_in
BIN_W  7  binary result width and iteration count; must satisfy 2^BIN_W > 10^DIGITS - 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only when not busy
bcd_in  input  4*DIGITS  packed BCD operand, most significant digit in the high nibble; sampled with start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse, bin_out/err valid
bin_out  output  BIN_W  binary result; held until next done
err  output  1  invalid-digit flag; valid with done, held until next done

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, bin_out=0, err=0, FSM=IDLE, iteration counter=0, shift register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at edge E0:
  - Latch bcd_in into the BCD shift register and clear the binary accumulator.
  - Set busy=1 and counter=0, then go to RUN.
  - If any digit > 9 and checking is enabled, see Optional Feature instead.
- RUN, each edge:
  - Shift {bcd_reg, bin_acc} right by 1.
  - After the shift, subtract 3 from every BCD digit whose value is >= 8. Correction uses post-shift values, all digits in parallel within the same cycle.
  - Counter increments by 1.
- Completion at edge E_BIN_W, after the final iteration:
  - bin_out <= corrected accumulator; done=1; busy=0; err=0; state DONE.
  - Latency: done is high in the cycle following edge E_BIN_W (E7 for default).
- DONE: lasts one cycle.
  - done returns to 0 on the next edge.
  - Next state is IDLE, or RUN if start=1 in that cycle (back-to-back accepted).
- start while busy=1 is ignored. No queuing and no effect on the conversion in progress.
- bcd_in is don't-care except in the start-sampling cycle.
- Reset asserted mid-conversion aborts immediately. All outputs return to reset values; no done pulse is produced for the aborted operation.
- Boundaries:
  - bcd_in=0 gives bin_out=0.
  - Maximum input (all digits 9) gives 10^DIGITS - 1 with no overflow, guaranteed by the BIN_W constraint.

Optional Feature:
Macro: BCD2BIN_ERR_CHECK_EN
- Defined: at the start edge, every nibble is compared against 9.
  - If any nibble > 9: skip RUN; go directly to DONE with err=1, bin_out=0, busy stays 0.
  - done pulses in the cycle after E0.
- Not defined: no digit check.
  - err is tied 0.
  - Invalid nibbles are converted by the same algorithm. The result is deterministic but meaningless, and latency is always BIN_W+1.

Test Plan:
1. Reset, then start with bcd_in=8'h99 -> busy=1 from E0 to E7; done=1 only in the cycle after E7; bin_out=7'd99; err=0.
2. bcd_in=8'h00, then 8'h81 (9x9 product), then 8'h10 -> bin_out = 0, 81, 10 respectively; latency identical each time.
3. Start held high continuously with bcd_in=8'h42 -> conversions back-to-back; done pulses every 8 cycles; no start accepted while busy.
4. Start 8'h55, then assert rst_n=0 at iteration 3 -> busy=0, done never pulses, bin_out=0; after release, start 8'h12 -> bin_out=12.
5. With BCD2BIN_ERR_CHECK_EN defined: bcd_in=8'h3A -> done in the cycle after E0, err=1, bin_out=0. Then bcd_in=8'h37 -> err=0, bin_out=37.
6. Exhaustive sweep: every tens digit 0..9 times every units digit 0..9 -> bin_out equals 10*tens+units for all 100 codes, with self-checking compare.
